// File: rtl/lockctrl.sv
// Keypad lock controller: PIN entry, compare, timed error hold and auto-relock,
// with registered five-digit display codes and per-digit enables.
module lockctrl #(
   parameter logic [15:0] PASS     = 16'h1234,
   parameter logic [8:0]  ENTRY_TO = 9'd160,
   parameter logic [8:0]  OPEN_TO  = 9'd320,
   parameter logic [8:0]  ERR_TIME = 9'd64
) (
   input  logic       ck,
   input  logic       resetn,
   input  logic       hz32,
   input  logic       keyenbl,
   input  logic [3:0] keycode,
   output logic [3:0] dig4,
   output logic [3:0] dig3,
   output logic [3:0] dig2,
   output logic [3:0] dig1,
   output logic [3:0] dig0,
   output logic [4:0] dispen,
   output logic       lock
);

   typedef enum logic [1:0] {
      S_CLOSE,
      S_ENTRY,
      S_OPEN,
      S_ERROR
   } state_e;

   localparam logic [3:0]  KEY_STAR  = 4'ha;
   localparam logic [3:0]  KEY_HASH  = 4'hb;
   localparam logic [19:0] DIG_CLOSE = 20'hCB05E;
   localparam logic [19:0] DIG_OPEN  = 20'h00FED;
   localparam logic [19:0] DIG_ERROR = 20'hEAAAA;

   state_e      state_q, state_d;
   logic [8:0]  timer_q, timer_d;
   logic [15:0] buf_q, buf_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        hz32_q;
   logic [19:0] dig_q, dig_d;
   logic [4:0]  dispen_q, dispen_d;
   logic        lock_q, lock_d;

   logic       tick;
   logic       is_digit, is_star, is_hash;
   logic       key_acc;
   logic [8:0] timer_inc;

   assign tick      = hz32 & ~hz32_q;
   assign is_digit  = keyenbl && (keycode <= 4'd9);
   assign is_star   = keyenbl && (keycode == KEY_STAR);
   assign is_hash   = keyenbl && (keycode == KEY_HASH);
   assign timer_inc = timer_q + 9'd1;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      timer_d = tick ? timer_inc : timer_q;
      key_acc = 1'b0;

      unique case (state_q)
         S_CLOSE: begin
            if (is_digit) begin
               state_d = S_ENTRY;
               buf_d   = {12'h000, keycode};
               cnt_d   = 3'd1;
            end
         end
         S_ENTRY: begin
            if (is_digit) begin
               buf_d   = {buf_q[11:0], keycode};
               cnt_d   = (cnt_q >= 3'd4) ? 3'd4 : cnt_q + 3'd1;
               key_acc = 1'b1;
            end else if (is_hash) begin
               state_d = (cnt_q == 3'd4 && buf_q == PASS) ? S_OPEN : S_ERROR;
            end else if (is_star) begin
               state_d = S_CLOSE;
            end else if (tick && timer_inc == ENTRY_TO) begin
               state_d = S_CLOSE;
            end
         end
         S_OPEN: begin
            if (is_star || is_hash) begin
               state_d = S_CLOSE;
            end else if (tick && timer_inc == OPEN_TO) begin
               state_d = S_CLOSE;
            end
         end
         S_ERROR: begin
            if (tick && timer_inc == ERR_TIME) begin
               state_d = S_CLOSE;
            end
         end
         default: state_d = S_CLOSE;
      endcase

      // A key that acts wins over a coincident tick, which is then lost.
      if (state_d != state_q || key_acc) begin
         timer_d = 9'd0;
      end
      if (state_d != S_ENTRY) begin
         buf_d = 16'h0000;
         cnt_d = 3'd0;
      end
   end

   // Outputs are decoded from next-state values so they are registered yet
   // change on the same edge as the state.
   always_comb begin
      dig_d    = DIG_CLOSE;
      dispen_d = 5'b11111;
      lock_d   = 1'b1;
      unique case (state_d)
         S_CLOSE: begin
            dig_d = DIG_CLOSE;
         end
         S_ENTRY: begin
            dig_d    = {4'ha, buf_d};
            dispen_d = {1'b1, cnt_d >= 3'd4, cnt_d >= 3'd3, cnt_d >= 3'd2, cnt_d >= 3'd1};
         end
         S_OPEN: begin
            dig_d    = DIG_OPEN;
            dispen_d = 5'b01111;
            lock_d   = 1'b0;
         end
         S_ERROR: begin
            dig_d    = DIG_ERROR;
            dispen_d = timer_d[3] ? 5'b00000 : 5'b11111;
         end
         default: begin
            dig_d = DIG_CLOSE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge ck or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_CLOSE;
         timer_q  <= 9'd0;
         buf_q    <= 16'h0000;
         cnt_q    <= 3'd0;
         hz32_q   <= 1'b0;
         dig_q    <= DIG_CLOSE;
         dispen_q <= 5'b11111;
         lock_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         hz32_q   <= hz32;
         dig_q    <= dig_d;
         dispen_q <= dispen_d;
         lock_q   <= lock_d;
      end
   end

   assign dig4   = dig_q[19:16];
   assign dig3   = dig_q[15:12];
   assign dig2   = dig_q[11:8];
   assign dig1   = dig_q[7:4];
   assign dig0   = dig_q[3:0];
   assign dispen = dispen_q;
   assign lock   = lock_q;

endmodule

// File: tb/tb_lockctrl.sv
// Scoreboard bench for lockctrl: a digit-queue model predicts every cycle's
// outputs, a monitor compares them one ck later.
module tb_lockctrl;

   localparam int ENTRY_TO = 160;
   localparam int OPEN_TO  = 320;
   localparam int ERR_TIME = 64;
   localparam int PIN      = 1234;

   typedef enum {CLOSED, ENTERING, OPENED, ERRORED} mstate_e;
   typedef struct packed {
      logic [19:0] dig;
      logic [4:0]  en;
      logic        lock;
   } exp_t;

   logic       ck = 1'b0;
   logic       resetn = 1'b0;
   logic       hz32 = 1'b0;
   logic       keyenbl = 1'b0;
   logic [3:0] keycode = 4'h0;
   logic [3:0] dig4, dig3, dig2, dig1, dig0;
   logic [4:0] dispen;
   logic       lock;

   lockctrl dut (
      .ck      (ck),
      .resetn  (resetn),
      .hz32    (hz32),
      .keyenbl (keyenbl),
      .keycode (keycode),
      .dig4    (dig4),
      .dig3    (dig3),
      .dig2    (dig2),
      .dig1    (dig1),
      .dig0    (dig0),
      .dispen  (dispen),
      .lock    (lock)
   );

   always #5 ck = ~ck;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   // Reference model state
   mstate_e m_state = CLOSED;
   int      m_digits[$];
   int      m_ticks = 0;
   bit      m_hz_prev = 1'b0;
   int      phase = 0;

   task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [25:0] dut_out();
      return {dig4, dig3, dig2, dig1, dig0, dispen, lock};
   endfunction

   function automatic exp_t expected();
      exp_t e;
      int   n;
      e = '{dig: 20'hCB05E, en: 5'b11111, lock: 1'b1};
      case (m_state)
         ENTERING: begin
            n = m_digits.size();
            e.dig[19:16] = 4'ha;
            for (int k = 0; k < 4; k++) begin
               e.dig[4*k +: 4] = (k < n) ? 4'(m_digits[n-1-k]) : 4'h0;
               e.en[k] = (k < n);
            end
            e.en[4] = 1'b1;
         end
         OPENED: e = '{dig: 20'h00FED, en: 5'b01111, lock: 1'b0};
         ERRORED: begin
            e.dig = 20'hEAAAA;
            e.en  = (((m_ticks / 8) % 2) == 0) ? 5'b11111 : 5'b00000;
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic int pin_value();
      int v = 0;
      foreach (m_digits[i]) v = v * 10 + m_digits[i];
      return v;
   endfunction

   task automatic model_step(input bit en, input logic [3:0] code, input bit hz);
      bit      tick, acc, digit, star, hash;
      mstate_e nxt;
      tick = hz && !m_hz_prev;
      m_hz_prev = hz;
      digit = en && (code <= 4'd9);
      star  = en && (code == 4'ha);
      hash  = en && (code == 4'hb);
      nxt = m_state;
      acc = 1'b0;
      case (m_state)
         CLOSED: if (digit) begin
            m_digits.delete();
            m_digits.push_back(int'(code));
            nxt = ENTERING;
         end
         ENTERING: begin
            if (digit) begin
               m_digits.push_back(int'(code));
               if (m_digits.size() > 4) void'(m_digits.pop_front());
               acc = 1'b1;
            end else if (hash) begin
               nxt = (m_digits.size() == 4 && pin_value() == PIN) ? OPENED : ERRORED;
            end else if (star) begin
               nxt = CLOSED;
            end else if (tick) begin
               m_ticks++;
               if (m_ticks == ENTRY_TO) nxt = CLOSED;
            end
         end
         OPENED: begin
            if (star || hash) nxt = CLOSED;
            else if (tick) begin
               m_ticks++;
               if (m_ticks == OPEN_TO) nxt = CLOSED;
            end
         end
         ERRORED: if (tick) begin
            m_ticks++;
            if (m_ticks == ERR_TIME) nxt = CLOSED;
         end
         default: ;
      endcase
      if (nxt != m_state || acc) m_ticks = 0;
      if (nxt != ENTERING) m_digits.delete();
      m_state = nxt;
   endtask

   task automatic model_reset();
      m_state = CLOSED;
      m_digits.delete();
      m_ticks = 0;
      m_hz_prev = 1'b0;
   endtask

   // One ck of stimulus: hz32 runs at a 4-ck period, one tick per period.
   task automatic step(input bit en, input logic [3:0] code);
      bit hz;
      @(negedge ck);
      hz = (phase % 4) < 2;
      phase++;
      hz32    = hz;
      keyenbl = en;
      keycode = code;
      model_step(en, code, hz);
      exp_q.push_back(expected());
   endtask

   task automatic press(input logic [3:0] code);
      step(1'b1, code);
      step(1'b0, 4'h0);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < 4 * n; i++) step(1'b0, 4'h0);
   endtask

   // Monitor: every cycle the DUT presents outputs, checked against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge ck);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", dut_out(), e);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state held across clock edges
      repeat (2) @(posedge ck);
      #3;
      check("reset_state", dut_out(), {20'hCB05E, 5'b11111, 1'b1});
      phase = 2;
      hz32 = 1'b0;
      resetn = 1'b1;
      model_reset();

      // Correct PIN, then auto-relock after OPEN_TO ticks
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hb);
      idle_ticks(OPEN_TO + 4);

      // Oldest digit drops out, still opens; '*' relocks
      press(4'd9); press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hb);
      press(4'ha);

      // Short entry -> ERROR; keys ignored during the blink, then back to CLOSE
      press(4'd1); press(4'd2); press(4'd3); press(4'hb);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 4'($urandom_range(0, 15)));
         step(1'b0, 4'h0);
         step(1'b0, 4'h0);
      end
      idle_ticks(ERR_TIME + 4);

      // Entry timeout with two digits
      press(4'd7); press(4'd8);
      idle_ticks(ENTRY_TO + 4);

      // Key near tick 150 restarts the entry timer
      press(4'd5); press(4'd6);
      idle_ticks(149);
      press(4'd7);
      idle_ticks(20);
      idle_ticks(ENTRY_TO);

      // Key coincident with a tick, '*' and an ignored keycode in ENTRY
      press(4'd3);
      while ((phase % 4) != 0) step(1'b0, 4'h0);
      step(1'b1, 4'd4);
      press(4'hd);
      idle_ticks(ENTRY_TO - 1);
      press(4'hd);
      press(4'ha);
      idle_ticks(2);

      // Async reset while OPEN takes effect between edges
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hb);
      idle_ticks(3);
      @(posedge ck);
      #3;
      resetn = 1'b0;
      #1;
      check("async_reset", dut_out(), {20'hCB05E, 5'b11111, 1'b1});
      @(posedge ck);
      #3;
      phase = 2;
      hz32 = 1'b0;
      resetn = 1'b1;
      model_reset();

      // Randomized keys, with the correct PIN injected now and then
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd4);
            if ($urandom_range(0, 1) == 1) press(4'hb);
         end else if ($urandom_range(0, 7) == 0) begin
            step(1'b1, 4'($urandom_range(0, 15)));
         end else begin
            step(1'b0, 4'($urandom_range(0, 15)));
         end
      end

      repeat (3) @(posedge ck);
      #2;
      check("drain", 26'(exp_q.size()), 26'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
